// File: rtl/bcd_seq.sv
// bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Converts a WIDTH-bit unsigned or two's-complement value into DIGITS packed BCD digits,
// reporting sign and whether the magnitude overflowed the available digits.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        conversion request, sampled only while idle
//   signed_mode  1 = din is two's complement, sampled with start
//   din          binary value, sampled with start
//   busy         conversion in progress
//   done         one-cycle pulse when digits/negative/overflow update
//   digits       BCD result, digit k at [4k+3:4k], digit 0 = units
//   negative     result is negative
//   overflow     magnitude >= 10^DIGITS; digits hold magnitude mod 10^DIGITS
module bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  negative,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   digits_d;
    logic               negative_d;
    logic               overflow_d;
    logic               done_d;
    logic               busy_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic               carry_out;

    // Add-3 correction: every digit >= 5 is adjusted from its pre-shift value.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift the next magnitude bit in; the bit leaving the top digit signals overflow.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
    assign carry_out = bcd_adj[BCD_W-1];

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        ovf_acc_d  = ovf_acc_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        digits_d   = digits;
        negative_d = negative;
        overflow_d = overflow;
        done_d     = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Negation of the most-negative value yields 2^(WIDTH-1), correct as unsigned.
                    if (signed_mode && din[WIDTH-1]) begin
                        mag_d = ~din + WIDTH'(1);
                    end else begin
                        mag_d = din;
                    end
                    sign_d    = signed_mode & din[WIDTH-1];
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    state_d   = SHIFT;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                bcd_d     = bcd_shift;
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    digits_d   = bcd_shift;
                    negative_d = sign_q;
                    overflow_d = ovf_acc_q | carry_out;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            digits    <= '0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            digits    <= digits_d;
            negative  <= negative_d;
            overflow  <= overflow_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

endmodule
